// File: rtl/reg_file_wr_arbiter_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
package reg_file_wr_arbiter_pkg;

  localparam int unsigned DATA_LEN_DEF     = 32;
  localparam int unsigned ADDR_LEN_DEF     = 5;
  localparam int unsigned REG_LEN_DEF      = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Width of the starvation counter; holds STARVE_LIMIT up to 15.
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic {
    StArb   = 1'b0,
    StClear = 1'b1
  } arb_state_e;

endpackage

// File: rtl/reg_file_wr_arbiter.sv
// Write-port arbiter and clear sequencer in front of the integer register file.
// Core writeback has priority; debug writes get through when the core is idle or
// after STARVE_LIMIT denied cycles. A clear request zero-fills x1..x(REG_LEN-1).
module reg_file_wr_arbiter
  import reg_file_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_LEN     = DATA_LEN_DEF,
  parameter int unsigned ADDR_LEN     = ADDR_LEN_DEF,
  parameter int unsigned REG_LEN      = REG_LEN_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_core_we,
  input  logic [ADDR_LEN-1:0] i_core_addr,
  input  logic [DATA_LEN-1:0] i_core_data,
  output logic                o_core_stall,
  input  logic                i_dbg_valid,
  input  logic [ADDR_LEN-1:0] i_dbg_addr,
  input  logic [DATA_LEN-1:0] i_dbg_data,
  output logic                o_dbg_ready,
  input  logic                i_clear_req,
  output logic                o_clear_busy,
  output logic                o_rf_we,
  output logic [ADDR_LEN-1:0] o_rf_addr,
  output logic [DATA_LEN-1:0] o_rf_data
);

  localparam logic [ADDR_LEN-1:0]     LastIdx  = ADDR_LEN'(REG_LEN - 1);
  localparam logic [STARVE_CNT_W-1:0] StarveMx = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e                state_q, state_d;
  logic [ADDR_LEN-1:0]       clr_idx_q, clr_idx_d;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic core_req;
  logic dbg_ready;
  logic dbg_grant;

  // Writes to x0 are not real requests and must never hold off debug.
  assign core_req  = i_core_we && (i_core_addr != '0);
  assign dbg_ready = (state_q == StArb) && (!core_req || (starve_cnt_q == StarveMx));
  assign dbg_grant = dbg_ready && i_dbg_valid;

  // Grant selection and write-port mux; everything is forced idle during reset.
  always_comb begin
    o_rf_we      = 1'b0;
    o_rf_addr    = '0;
    o_rf_data    = '0;
    o_core_stall = 1'b0;
    o_dbg_ready  = 1'b0;
    o_clear_busy = 1'b0;
    if (!i_rst) begin
      if (state_q == StClear) begin
        o_rf_we      = 1'b1;
        o_rf_addr    = clr_idx_q;
        o_core_stall = i_core_we;
        o_clear_busy = 1'b1;
      end else begin
        o_dbg_ready = dbg_ready;
        if (dbg_grant) begin
          o_core_stall = core_req;
          // A debug write to x0 still handshakes but never reaches the file.
          if (i_dbg_addr != '0) begin
            o_rf_we   = 1'b1;
            o_rf_addr = i_dbg_addr;
            o_rf_data = i_dbg_data;
          end
        end else if (core_req) begin
          o_rf_we   = 1'b1;
          o_rf_addr = i_core_addr;
          o_rf_data = i_core_data;
        end
      end
    end
  end

  // Next-state for the FSM, clear index and starvation counter.
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q == StClear) begin
      starve_cnt_d = '0;
      if (clr_idx_q == LastIdx) begin
        state_d   = StArb;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end else begin
      if (dbg_grant || !i_dbg_valid) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != StarveMx) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
      if (i_clear_req) begin
        state_d   = StClear;
        clr_idx_d = ADDR_LEN'(1);
      end
    end
  end

  // State registers with synchronous reset; reset mid-clear simply aborts it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StArb;
      clr_idx_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: doc/reg_file_wr_arbiter.md
# reg_file_wr_arbiter

Write-port arbiter and clear sequencer in front of the single write port of the integer register file. It shares that port between two requesters: core writeback, which has priority, and the debug/host write port, which uses a valid/ready handshake and has a starvation guard. It also runs a multi-cycle clear of x1..x31 on request. The block sits between the writeback mux and the register file write inputs.

## Interface
Parameters:
- DATA_LEN, 32, register width
- ADDR_LEN, 5, register address width
- REG_LEN, 32, number of registers
- STARVE_LIMIT, 4, consecutive denied debug cycles before debug is forced through (1..15)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous active-high reset
- i_core_we  in  1  core writeback request
- i_core_addr  in  ADDR_LEN  core destination register
- i_core_data  in  DATA_LEN  core writeback data
- o_core_stall  out  1  core write not taken this cycle; core holds PC and retries
- i_dbg_valid  in  1  debug write request
- i_dbg_addr  in  ADDR_LEN  debug destination register
- i_dbg_data  in  DATA_LEN  debug write data
- o_dbg_ready  out  1  debug write accepted when high together with i_dbg_valid
- i_clear_req  in  1  single-cycle pulse requesting a zero-fill of x1..x31
- o_clear_busy  out  1  clear sequence in progress
- o_rf_we / o_rf_addr / o_rf_data  out  1 / ADDR_LEN / DATA_LEN  register file write port

## Operation
- **States:** ARB, CLEAR. Reset enters ARB with starve_cnt=0 and clr_idx=0.
- **core_req** = i_core_we && i_core_addr!=0. A core write to x0 is not a request and never blocks debug.
- **ARB, default:** core wins.
  - o_rf_* = core fields; o_core_stall=0; o_dbg_ready=0.
- **ARB, debug path:**
  - o_dbg_ready = !core_req || starve_cnt==STARVE_LIMIT. It does not depend on i_dbg_valid.
  - Debug is granted when ready && valid.
  - A granted write to x0 completes the handshake, but o_rf_we=0.
  - When debug wins while core_req is high, o_core_stall=1.
- **starve_cnt:**
  - Increments each cycle with i_dbg_valid && !o_dbg_ready, saturating at STARVE_LIMIT.
  - Clears on a debug grant or when i_dbg_valid=0.
- **ARB to CLEAR:** i_clear_req in ARB moves to CLEAR next cycle, with clr_idx=1. The write granted in the request cycle still happens.
- **CLEAR:**
  - o_rf_we=1, o_rf_addr=clr_idx, o_rf_data=0.
  - o_core_stall = i_core_we (any write, x0 included, is held off).
  - o_dbg_ready=0; o_clear_busy=1.
  - clr_idx increments each cycle. After the cycle with clr_idx==REG_LEN-1, return to ARB and clear starve_cnt.
- **i_clear_req during CLEAR:** ignored; the request is not queued.
- **Idle outputs:** with no grant, o_rf_we=0, o_rf_addr=0, o_rf_data=0.

## Timing
- All o_rf_*, o_core_stall and o_dbg_ready are combinational from inputs and state. The register file samples them at the same posedge, so write latency is 0 cycles.
- While i_rst=1, outputs are forced:
  - o_rf_we=0, o_rf_addr=0, o_rf_data=0
  - o_dbg_ready=0, o_core_stall=0, o_clear_busy=0
- Reset mid-CLEAR aborts the clear; registers not yet written keep their values. The next cycle is ARB.
- Clear duration is exactly REG_LEN-1 cycles (31 by default). o_clear_busy rises the cycle after the request and falls the cycle after the x31 write.
- **Worst-case debug wait** under continuous core writes is STARVE_LIMIT cycles. Debug wins in cycle STARVE_LIMIT+1 after it first asserts valid.
- **Worst-case core stall** is 1 cycle per forced debug grant, or REG_LEN-1 cycles during a clear.
- **Simultaneous events:**
  - Clear request plus debug grant in the same cycle: the debug write completes and the clear starts next cycle.
  - Debug valid at the clear request: debug waits out the whole clear.

## Structure
- DATA_LEN, REG_FILE_ADDR_LEN and REG_FILE_LEN come from the shared RISC-V_DEFINES.vh header; parameters default to those values.
- Add to the same header: state encodings (ARB=1'b0, CLEAR=1'b1) and a default STARVE_LIMIT define.
- Single module, no sub-module. Contents: one FSM register, a clr_idx counter of ADDR_LEN bits, a starve_cnt counter of 4 bits, and a combinational grant/mux block.

## Test plan
- **Core only:** core writes x5=0xDEADBEEF with debug idle -> o_rf_we=1, addr=5, data=0xDEADBEEF; stall=0.
- **Debug on idle core:** i_dbg_valid, addr=7, data=0x1234 with core idle -> ready=1 same cycle; rf x7=0x1234. A core write to x0 in that cycle does not block debug.
- **Starvation:** core writes every cycle and debug is valid continuously with STARVE_LIMIT=4 -> ready=0 for 4 cycles; cycle 5 has ready=1, stall=1 and the debug write lands; the counter then clears.
- **Clear:** registers preloaded with nonzero values, pulse i_clear_req -> busy for 31 cycles; writes to addr 1..31 with data 0; x0 untouched; stall follows i_core_we; ready=0 throughout; the second pulse mid-clear is ignored.
- **Reset mid-clear:** assert i_rst at clr_idx=10 -> outputs go to reset values; x10..x31 keep their prior values; the next cycle is ARB with busy=0.
- **Simultaneous:** clear pulse plus debug grant in the same cycle -> the debug write completes, then the 31-cycle clear follows.
